// File: rtl/updown_counter_mod.sv
// Parametrised up/down event counter: runtime modulus and step, wrap or saturate, tc pulse, sticky ovf.
// Optional enable prescaler is built only when COUNTER_PRESCALE_EN is defined.
module updown_counter_mod #(
   parameter int WIDTH    = 8,
   parameter int STEP_W   = 4,
   parameter int PRESCALE = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              up_down,
   input  logic              enable,
   input  logic [WIDTH-1:0]  d_in,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  limit,
   input  logic              sat_mode,
   input  logic              clr_ovf,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              ovf
);

   localparam int XW = WIDTH + 1;

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             step_evt_s;
   logic             bnd_s;

   logic [XW-1:0] cnt_x_s, step_x_s, lim_x_s, mod_x_s;
   logic [XW-1:0] sum_x_s, wrap_up_x_s, dn_x_s, diff_x_s, wrap_dn_x_s;

`ifdef COUNTER_PRESCALE_EN
   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre_q, pre_d;

   // Prescaler advances on qualified enables; only its last phase yields a step event.
   always_comb begin
      pre_d      = pre_q;
      step_evt_s = 1'b0;
      if (load) begin
         pre_d = '0;
      end else if (enable) begin
         if (pre_q == PW'(PRESCALE - 1)) begin
            pre_d      = '0;
            step_evt_s = 1'b1;
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end else begin
         pre_d = pre_q;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end
`else
   assign step_evt_s = enable & ~load;
`endif

   // One extra bit so M = limit+1 can reach 2^WIDTH and sums never overflow.
   assign cnt_x_s     = {1'b0, count_q};
   assign step_x_s    = XW'(step);
   assign lim_x_s     = {1'b0, limit};
   assign mod_x_s     = lim_x_s + XW'(1);
   assign sum_x_s     = cnt_x_s + step_x_s;
   assign wrap_up_x_s = sum_x_s - mod_x_s;
   assign dn_x_s      = cnt_x_s - step_x_s;
   assign diff_x_s    = step_x_s - cnt_x_s;
   assign wrap_dn_x_s = mod_x_s - diff_x_s;

   // Next count, terminal-count pulse and sticky overflow.
   always_comb begin
      count_d = count_q;
      bnd_s   = 1'b0;
      if (load) begin
         count_d = (d_in > limit) ? limit : d_in;
      end else if (step_evt_s && (step_x_s != XW'(0))) begin
         if (cnt_x_s > lim_x_s) begin
            count_d = limit;
            bnd_s   = 1'b1;
         end else if (up_down) begin
            if (sum_x_s <= lim_x_s) begin
               count_d = sum_x_s[WIDTH-1:0];
            end else begin
               bnd_s = 1'b1;
               if (sat_mode) begin
                  count_d = limit;
               end else if (wrap_up_x_s > lim_x_s) begin
                  count_d = '0;
               end else begin
                  count_d = wrap_up_x_s[WIDTH-1:0];
               end
            end
         end else begin
            if (cnt_x_s >= step_x_s) begin
               count_d = dn_x_s[WIDTH-1:0];
            end else begin
               bnd_s = 1'b1;
               // A step larger than the modulus would go negative: pin to limit.
               if (sat_mode) begin
                  count_d = '0;
               end else if (diff_x_s > mod_x_s) begin
                  count_d = limit;
               end else begin
                  count_d = wrap_dn_x_s[WIDTH-1:0];
               end
            end
         end
      end else begin
         count_d = count_q;
      end
      tc_d = bnd_s;
      if (bnd_s) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod: directed scenarios plus randomized traffic
// against an integer reference model. Prescaler scenario runs when COUNTER_PRESCALE_EN is defined.
module tb_updown_counter_mod;

   localparam int W  = 8;
   localparam int SW = 4;
   localparam int PS = 4;

   logic          clk = 1'b0;
   logic          rst_n, load, up_down, enable, sat_mode, clr_ovf;
   logic [W-1:0]  d_in, limit;
   logic [SW-1:0] step;
   logic [W-1:0]  count;
   logic          tc, ovf;

   int  vecs = 0;
   int  errs = 0;
   int  m_count = 0;
   int  m_pre = 0;
   bit  m_tc = 1'b0;
   bit  m_ovf = 1'b0;

   updown_counter_mod #(.WIDTH(W), .STEP_W(SW), .PRESCALE(PS)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .up_down(up_down), .enable(enable),
      .d_in(d_in), .step(step), .limit(limit), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
      .count(count), .tc(tc), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic on the counting rules.
   task automatic model_advance();
      int  c, lim, st, r;
      bit  bnd, ev;
      if (!rst_n) begin
         m_count = 0; m_tc = 1'b0; m_ovf = 1'b0; m_pre = 0;
         return;
      end
      c = m_count; lim = int'(limit); st = int'(step); bnd = 1'b0; ev = 1'b0;
      if (load) begin
         c = (int'(d_in) > lim) ? lim : int'(d_in);
         m_pre = 0;
      end else if (enable) begin
`ifdef COUNTER_PRESCALE_EN
         if (m_pre == PS - 1) begin m_pre = 0; ev = 1'b1; end
         else m_pre = m_pre + 1;
`else
         ev = 1'b1;
`endif
      end
      if (ev && st != 0) begin
         if (c > lim) begin
            c = lim; bnd = 1'b1;
         end else if (up_down) begin
            if (c + st <= lim) c = c + st;
            else begin
               bnd = 1'b1;
               if (sat_mode) c = lim;
               else begin r = c + st - (lim + 1); c = (r > lim) ? 0 : r; end
            end
         end else begin
            if (c >= st) c = c - st;
            else begin
               bnd = 1'b1;
               if (sat_mode) c = 0;
               else begin r = c + (lim + 1) - st; c = (r < 0 || r > lim) ? lim : r; end
            end
         end
      end
      m_count = c;
      m_tc    = bnd;
      m_ovf   = bnd ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
   endtask

   task automatic cycle();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load = 1'b1; d_in = 8'h55; limit = 8'hFF;
      cycle(); cycle();
      vecs++;
      if ({count, tc, ovf} !== {8'h00, 1'b0, 1'b0}) begin
         errs++; $display("FAIL reset: got count=%h tc=%b ovf=%b, want 00 0 0", count, tc, ovf);
      end
      rst_n = 1'b1; d_in = 8'hF0; limit = 8'h64;
      cycle();
      vecs++;
      if ({count, tc, ovf} !== {8'h64, 1'b0, 1'b0}) begin
         errs++; $display("FAIL load_clamp: got count=%h tc=%b ovf=%b, want 64 0 0", count, tc, ovf);
      end
      load = 1'b0;
   endtask

   task automatic test_wrap();
      limit = 8'h09; sat_mode = 1'b0; load = 1'b1; d_in = 8'h07;
      cycle();
      load = 1'b0; up_down = 1'b1; step = 4'd3; enable = 1'b1;
      cycle();
      vecs++;
      if ({count, tc, ovf} !== {8'h00, 1'b1, 1'b1}) begin
         errs++; $display("FAIL wrap_up: got count=%h tc=%b ovf=%b, want 00 1 1", count, tc, ovf);
      end
      cycle();
      vecs++;
      if ({count, tc, ovf} !== {8'h03, 1'b0, 1'b1}) begin
         errs++; $display("FAIL wrap_next: got count=%h tc=%b ovf=%b, want 03 0 1", count, tc, ovf);
      end
      enable = 1'b0; clr_ovf = 1'b1;
      cycle();
      clr_ovf = 1'b0;
      vecs++;
      if ({count, tc, ovf} !== {8'h03, 1'b0, 1'b0}) begin
         errs++; $display("FAIL clr_ovf: got count=%h tc=%b ovf=%b, want 03 0 0", count, tc, ovf);
      end
   endtask

   task automatic test_sat();
      sat_mode = 1'b1; load = 1'b1; d_in = 8'h02;
      cycle();
      load = 1'b0; up_down = 1'b0; step = 4'd4; enable = 1'b1;
      cycle();
      vecs++;
      if ({count, tc, ovf} !== {8'h00, 1'b1, 1'b1}) begin
         errs++; $display("FAIL sat_down: got count=%h tc=%b ovf=%b, want 00 1 1", count, tc, ovf);
      end
      clr_ovf = 1'b1;
      cycle();
      clr_ovf = 1'b0; enable = 1'b0;
      vecs++;
      if ({count, tc, ovf} !== {8'h00, 1'b1, 1'b1}) begin
         errs++; $display("FAIL sat_set_wins: got count=%h tc=%b ovf=%b, want 00 1 1", count, tc, ovf);
      end
   endtask

   task automatic test_full_range();
      limit = 8'hFF; sat_mode = 1'b0; load = 1'b1; d_in = 8'hFE;
      cycle();
      load = 1'b0; up_down = 1'b1; step = 4'd2; enable = 1'b1;
      cycle();
      vecs++;
      if ({count, tc} !== {8'h00, 1'b1}) begin
         errs++; $display("FAIL full_wrap: got count=%h tc=%b, want 00 1", count, tc);
      end
      step = 4'd0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         vecs++;
         if ({count, tc} !== {8'h00, 1'b0}) begin
            errs++; $display("FAIL step_zero[%0d]: got count=%h tc=%b, want 00 0", i, count, tc);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_load_priority();
      logic [W-1:0] exp_c [5];
      exp_c = '{8'h01, 8'h02, 8'h20, 8'h21, 8'h00};
      limit = 8'hFF; load = 1'b1; d_in = 8'h00;
      cycle();
      load = 1'b0; up_down = 1'b1; step = 4'd1; enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         load  = (i == 2);
         d_in  = 8'h20;
         rst_n = (i != 4);
         cycle();
         vecs++;
         if (count !== exp_c[i]) begin
            errs++; $display("FAIL load_prio[%0d]: got count=%h, want %h", i, count, exp_c[i]);
         end
      end
      rst_n = 1'b1; load = 1'b0; enable = 1'b0;
   endtask

`ifdef COUNTER_PRESCALE_EN
   task automatic test_prescale();
      bit           en_seq [6];
      logic [W-1:0] exp_c  [6];
      en_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_c  = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03};
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1; limit = 8'hFF; up_down = 1'b1; step = 4'd1; enable = 1'b1; sat_mode = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cycle();
         vecs++;
         if (count !== 8'(i / 4)) begin
            errs++; $display("FAIL prescale[%0d]: got count=%h, want %h", i, count, 8'(i / 4));
         end
      end
      for (int i = 0; i < 6; i++) begin
         enable = en_seq[i];
         cycle();
         vecs++;
         if (count !== exp_c[i]) begin
            errs++; $display("FAIL prescale_gap[%0d]: got count=%h, want %h", i, count, exp_c[i]);
         end
      end
      enable = 1'b0;
   endtask
`endif

   task automatic test_random();
      logic [W-1:0] lim_pick [4];
      lim_pick = '{8'h00, 8'hFF, 8'h09, 8'h80};
      for (int i = 0; i < 1500; i++) begin
         rst_n    = ($urandom_range(0, 59) != 0);
         load     = ($urandom_range(0, 9) == 0);
         up_down  = 1'($urandom);
         enable   = ($urandom_range(0, 3) != 0);
         d_in     = 8'($urandom);
         step     = 4'($urandom);
         clr_ovf  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) sat_mode = 1'($urandom);
         if ($urandom_range(0, 11) == 0)
            limit = ($urandom_range(0, 1) != 0) ? lim_pick[$urandom_range(0, 3)] : 8'($urandom);
         cycle();
         vecs++;
         if ({count, tc, ovf} !== {8'(m_count), m_tc, m_ovf}) begin
            errs++;
            $display("FAIL random[%0d]: got count=%h tc=%b ovf=%b, want %h %b %b",
                     i, count, tc, ovf, 8'(m_count), m_tc, m_ovf);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; up_down = 1'b1; enable = 1'b0; sat_mode = 1'b0;
      clr_ovf = 1'b0; d_in = 8'h00; limit = 8'hFF; step = 4'd0;
      #2;
      test_reset();
`ifdef COUNTER_PRESCALE_EN
      test_prescale();
`else
      test_wrap();
      test_sat();
      test_full_range();
      test_load_priority();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
